// File: rtl/fdp_sum_round_if.sv
// Handshake and data bundle between the FP16 multiplier stage, the
// sum/round stage and the consumer of the packed FP16 result.
interface fdp_sum_round_if;
  // Input term set: two unrounded products plus an FP16 addend
  logic        in_valid;
  logic        in_ready;
  logic        p0_sign;
  logic        p1_sign;
  logic [5:0]  p0_exp;
  logic [5:0]  p1_exp;
  logic [21:0] p0_man;
  logic [21:0] p1_man;
  logic [15:0] c;
  // Rounded FP16 result
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;

  // The sum/round stage itself
  modport slave (
    input  in_valid,
    output in_ready,
    input  p0_sign,
    input  p1_sign,
    input  p0_exp,
    input  p1_exp,
    input  p0_man,
    input  p1_man,
    input  c,
    output out_valid,
    input  out_ready,
    output out
  );

  // Producer of the terms and consumer of the result
  modport master (
    output in_valid,
    input  in_ready,
    output p0_sign,
    output p1_sign,
    output p0_exp,
    output p1_exp,
    output p0_man,
    output p1_man,
    output c,
    input  out_valid,
    output out_ready,
    input  out
  );
endinterface

// File: rtl/fdp_sum_round.sv
// fdp_sum_round: sums two unrounded FP16 products and an FP16 addend with a
// single round-to-nearest-even step. Three registered stages:
//   1) align all terms to the largest exponent, collecting sticky bits
//   2) signed add in 37-bit two's complement, convert to sign/magnitude
//   3) normalize, round, pack (with overflow to inf and flush to zero)
// Significand scale: bit 32 of an aligned term is 1.0 at exponent Emax.
// Output backpressure stalls the whole pipeline; there is no skid buffer.
module fdp_sum_round (
  input  logic clk,
  input  logic rst,
  fdp_sum_round_if.slave io_bus
);

  // Aligns one term: {sticky, 34-bit aligned significand}
  function automatic logic [34:0] align_term(input logic [21:0] sig,
                                             input logic [6:0]  e,
                                             input logic [6:0]  emax,
                                             input logic        nz);
    logic [33:0] ext;
    logic [6:0]  sh;
    logic [33:0] mask;
    logic [33:0] shifted;
    logic        stk;
    ext  = {sig, 12'h000};
    sh   = emax - e;
    mask = 34'h0;
    if (!nz) begin
      shifted = 34'h0;
      stk     = 1'b0;
    end else if (sh >= 7'd34) begin
      // Everything falls below the window: only the sticky survives
      shifted = 34'h0;
      stk     = |ext;
    end else begin
      shifted = ext >> sh;
      mask    = ~({34{1'b1}} << sh);
      stk     = |(ext & mask);
    end
    return {stk, shifted};
  endfunction

  // Sign-applies an aligned magnitude in 37-bit two's complement
  function automatic logic [36:0] signed_term(input logic [33:0] mag,
                                              input logic        neg);
    logic [36:0] t;
    t = {3'b000, mag};
    return neg ? (~t + 37'd1) : t;
  endfunction

  // Position of the most significant set bit (0 when the vector is zero)
  function automatic logic [5:0] lead_one(input logic [36:0] v);
    logic [5:0] p;
    p = 6'd0;
    for (int i = 0; i < 37; i++) begin
      p = v[i] ? 6'(i) : p;
    end
    return p;
  endfunction

  logic w_stall;

  // Stage 0 (combinational from inputs)
  logic [6:0]  w_e0, w_e1, w_e2;
  logic        w_nz0, w_nz1, w_nz2;
  logic [6:0]  w_m0, w_m1, w_emax;
  logic [34:0] w_al0, w_al1, w_al2;

  // Stage 1 registers
  logic        r_v1;
  logic        r_zero1;
  logic [6:0]  r_emax1;
  logic [2:0]  r_sgn1;
  logic [2:0]  r_stk1;
  logic [33:0] r_a0, r_a1, r_a2;

  // Stage 2 combinational and registers
  logic [36:0] w_sum;
  logic        w_sgn2;
  logic [36:0] w_mag2;
  logic        r_v2;
  logic        r_zero2;
  logic [6:0]  r_emax2;
  logic        r_sgn2;
  logic [36:0] r_mag2;
  logic        r_stk2;

  // Stage 3 combinational and output registers
  logic [5:0]        w_lead;
  logic [36:0]       w_norm;
  logic              w_g;
  logic              w_s;
  logic              w_inc;
  logic [10:0]       w_rnd;
  logic [9:0]        w_esum;
  logic signed [9:0] w_ebias;
  logic [15:0]       w_res;
  logic              r_out_valid;
  logic [15:0]       r_out;

  // Handshake: hold everything while a result waits for the consumer
  assign w_stall          = r_out_valid & ~io_bus.out_ready;
  assign io_bus.in_ready  = ~w_stall;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out       = r_out;

  // Term exponents; the addend is rebiased to the product exponent scale
  assign w_e0  = {1'b0, io_bus.p0_exp};
  assign w_e1  = {1'b0, io_bus.p1_exp};
  assign w_e2  = {2'b00, io_bus.c[14:10]} + 7'd15;
  assign w_nz0 = |io_bus.p0_man;
  assign w_nz1 = |io_bus.p1_man;
  assign w_nz2 = |io_bus.c[14:10];

  // Largest exponent among the non-zero terms
  assign w_m0   = w_nz0 ? w_e0 : 7'd0;
  assign w_m1   = (w_nz1 && (w_e1 > w_m0)) ? w_e1 : w_m0;
  assign w_emax = (w_nz2 && (w_e2 > w_m1)) ? w_e2 : w_m1;

  assign w_al0 = align_term(io_bus.p0_man, w_e0, w_emax, w_nz0);
  assign w_al1 = align_term(io_bus.p1_man, w_e1, w_emax, w_nz1);
  assign w_al2 = align_term({1'b0, 1'b1, io_bus.c[9:0], 10'h000}, w_e2, w_emax, w_nz2);

  // Stage 2 adder and magnitude conversion
  assign w_sum  = signed_term(r_a0, r_sgn1[0]) + signed_term(r_a1, r_sgn1[1])
                + signed_term(r_a2, r_sgn1[2]);
  assign w_sgn2 = w_sum[36];
  assign w_mag2 = w_sgn2 ? (~w_sum + 37'd1) : w_sum;

  // Stage 3 normalize: hidden bit lands on bit 36, fraction on 35:26
  assign w_lead  = lead_one(r_mag2);
  assign w_norm  = r_mag2 << (6'd36 - w_lead);
  assign w_g     = w_norm[25];
  assign w_s     = (|w_norm[24:0]) | r_stk2;
  assign w_inc   = w_g & (w_s | w_norm[26]);
  assign w_rnd   = {1'b0, w_norm[35:26]} + {10'd0, w_inc};
  // Biased exponent = Emax - 15 + (L - 32) + carry
  assign w_esum  = {3'd0, r_emax2} + {4'd0, w_lead} + {9'd0, w_rnd[10]};
  assign w_ebias = $signed(w_esum) - 10'sd47;

  // Packs the rounded result, handling zero, overflow and underflow
  always_comb begin
    w_res = 16'h0000;
    if (r_zero2 || !w_norm[36]) begin
      w_res = 16'h0000;
    end else if (w_ebias >= 10'sd31) begin
      w_res = {r_sgn2, 5'h1F, 10'h000};
    end else if (w_ebias <= 10'sd0) begin
      w_res = {r_sgn2, 15'h0000};
    end else begin
      w_res = {r_sgn2, w_ebias[4:0], w_rnd[9:0]};
    end
  end

  // Pipeline registers: advance together unless the output is stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1        <= 1'b0;
      r_zero1     <= 1'b0;
      r_emax1     <= 7'd0;
      r_sgn1      <= 3'b000;
      r_stk1      <= 3'b000;
      r_a0        <= 34'h0;
      r_a1        <= 34'h0;
      r_a2        <= 34'h0;
      r_v2        <= 1'b0;
      r_zero2     <= 1'b0;
      r_emax2     <= 7'd0;
      r_sgn2      <= 1'b0;
      r_mag2      <= 37'h0;
      r_stk2      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out       <= 16'h0000;
    end else if (!w_stall) begin
      r_v1        <= io_bus.in_valid;
      r_zero1     <= ~(w_nz0 | w_nz1 | w_nz2);
      r_emax1     <= w_emax;
      r_sgn1      <= {io_bus.c[15], io_bus.p1_sign, io_bus.p0_sign};
      r_stk1      <= {w_al2[34], w_al1[34], w_al0[34]};
      r_a0        <= w_al0[33:0];
      r_a1        <= w_al1[33:0];
      r_a2        <= w_al2[33:0];
      r_v2        <= r_v1;
      r_zero2     <= r_zero1;
      r_emax2     <= r_emax1;
      r_sgn2      <= w_sgn2;
      r_mag2      <= w_mag2;
      r_stk2      <= |r_stk1;
      r_out_valid <= r_v2;
      r_out       <= r_v2 ? w_res : r_out;
    end
  end

endmodule

// File: tb/tb_fdp_sum_round.sv
// Scoreboard bench for fdp_sum_round: directed vectors with hand-computed
// FP16 results, a backpressure burst and an asynchronous mid-stream reset.
module tb_fdp_sum_round;
  localparam logic [21:0] ONE   = 22'h100000;
  localparam logic [21:0] THREE = 22'h300000;
  localparam int NV = 19;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fdp_sum_round_if bus ();
  fdp_sum_round dut (.clk(clk), .rst(rst), .io_bus(bus));

  typedef struct {
    logic        s0; logic [5:0] e0; logic [21:0] m0;
    logic        s1; logic [5:0] e1; logic [21:0] m1;
    logic [15:0] c;  logic [15:0] ex;
  } vec_t;
  typedef struct { logic [15:0] ex; int acc; bit chk; } sb_t;

  vec_t vt [NV];
  sb_t  sb [$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   head_seen = 1'b0;
  logic [15:0] cur_exp;
  bit   cur_chk;

  task automatic chk1(input string nm, input logic got, input logic req);
    n_vec++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %b, required %b (cycle %0d)", nm, got, req, cyc);
    end
  endtask

  task automatic send(input vec_t v, input bit lat);
    bit ok;
    @(posedge clk); #1;
    bus.p0_sign = v.s0; bus.p0_exp = v.e0; bus.p0_man = v.m0;
    bus.p1_sign = v.s1; bus.p1_exp = v.e1; bus.p1_man = v.m1;
    bus.c = v.c; cur_exp = v.ex; cur_chk = lat;
    bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int w = 0; w < 40 && !ok; w++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1");
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  // Cycle counter (posedges seen so far)
  initial forever @(posedge clk) cyc++;

  // Monitor: compare head of scoreboard whenever a result is presented
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (bus.out_valid) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_out: got %h, required no output", bus.out);
        end else begin
          if (bus.out !== sb[0].ex) begin
            n_err++;
            $display("FAIL result: got %h, required %h (cycle %0d)", bus.out, sb[0].ex, cyc);
          end
          if (sb[0].chk && !head_seen) begin
            n_vec++;
            if (cyc != sb[0].acc + 3) begin
              n_err++;
              $display("FAIL latency: got %0d cycles, required 3", cyc - sb[0].acc);
            end
          end
          head_seen = 1'b1;
          if (bus.out_ready) begin
            void'(sb.pop_front());
            head_seen = 1'b0;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) sb.push_back('{cur_exp, cyc, cur_chk});
    end
  end

  initial begin
    vt[0]  = '{1'b0, 6'd30, ONE,   1'b0, 6'd30, ONE,   16'h3C00, 16'h4200}; // 1+1+1
    vt[1]  = '{1'b0, 6'd30, ONE,   1'b1, 6'd30, ONE,   16'h3800, 16'h3800}; // cancel + 0.5
    vt[2]  = '{1'b0, 6'd30, ONE,   1'b1, 6'd30, ONE,   16'h0000, 16'h0000}; // exact zero
    vt[3]  = '{1'b0, 6'd19, ONE,   1'b0, 6'd0,  22'h0, 16'h3C00, 16'h3C00}; // tie, even
    vt[4]  = '{1'b0, 6'd19, ONE,   1'b0, 6'd0,  22'h0, 16'h3C01, 16'h3C02}; // tie, odd
    vt[5]  = '{1'b0, 6'd60, ONE,   1'b0, 6'd60, ONE,   16'h0000, 16'h7C00}; // +inf
    vt[6]  = '{1'b1, 6'd60, ONE,   1'b1, 6'd60, ONE,   16'h0000, 16'hFC00}; // -inf
    vt[7]  = '{1'b1, 6'd30, ONE,   1'b0, 6'd0,  22'h0, 16'h3800, 16'hB800}; // -1+0.5
    vt[8]  = '{1'b0, 6'd2,  ONE,   1'b0, 6'd0,  22'h0, 16'h0000, 16'h0000}; // underflow
    vt[9]  = '{1'b1, 6'd2,  ONE,   1'b0, 6'd0,  22'h0, 16'h0000, 16'h8000}; // -underflow
    vt[10] = '{1'b0, 6'd19, ONE,   1'b0, 6'd0,  22'h0, 16'h3FFF, 16'h4000}; // round carry
    vt[11] = '{1'b0, 6'd19, ONE,   1'b0, 6'd8,  ONE,   16'h3C00, 16'h3C01}; // tie+sticky
    vt[12] = '{1'b0, 6'd29, ONE,   1'b0, 6'd6,  ONE,   16'h6400, 16'h6401}; // sticky-only
    vt[13] = '{1'b0, 6'd30, THREE, 1'b0, 6'd0,  22'h0, 16'h0000, 16'h4200}; // product 3.0
    vt[14] = '{1'b0, 6'd0,  22'h0, 1'b0, 6'd0,  22'h0, 16'h83FF, 16'h0000}; // all zero
    vt[15] = '{1'b0, 6'd0,  22'h0, 1'b0, 6'd0,  22'h0, 16'h7BFF, 16'h7BFF}; // max normal
    vt[16] = '{1'b0, 6'd46, ONE,   1'b0, 6'd0,  22'h0, 16'h0000, 16'h7C00}; // exp 31
    vt[17] = '{1'b0, 6'd16, ONE,   1'b0, 6'd0,  22'h0, 16'h0000, 16'h0400}; // exp 1
    vt[18] = '{1'b0, 6'd15, ONE,   1'b0, 6'd0,  22'h0, 16'h0000, 16'h0000}; // exp 0

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.p0_sign = 1'b0; bus.p0_exp = 6'd0; bus.p0_man = 22'h0;
    bus.p1_sign = 1'b0; bus.p1_exp = 6'd0; bus.p1_man = 22'h0;
    bus.c = 16'h0000; cur_exp = 16'h0000; cur_chk = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk1("reset_out_valid", bus.out_valid, 1'b0);
    chk1("reset_out_zero", (bus.out == 16'h0000), 1'b1);
    chk1("reset_in_ready", bus.in_ready, 1'b1);
    rst = 1'b0;

    // Directed vectors back-to-back: full throughput, exact latency
    for (int i = 0; i < NV; i++) send(vt[i], 1'b1);
    idle(6);

    // Backpressure: 6 beats while out_ready is low for cycles 3..8
    fork
      begin
        for (int j = 0; j < 6; j++) send(vt[j], 1'b0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 14; k++) begin
          @(posedge clk); #1;
          bus.out_ready = (k < 3 || k > 8);
          @(negedge clk);
          chk1("bp_in_ready", bus.in_ready, (k < 3 || k > 8));
        end
      end
    join
    bus.out_ready = 1'b1;
    idle(8);

    // Asynchronous reset with results in flight
    send(vt[0], 1'b0);
    send(vt[1], 1'b0);
    send(vt[5], 1'b0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    #2;
    chk1("pre_rst_out_valid", bus.out_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk1("rst_out_zero", (bus.out == 16'h0000), 1'b1);
    chk1("rst_in_ready", bus.in_ready, 1'b1);
    sb.delete();
    head_seen = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk1("post_rst_idle", bus.out_valid, 1'b0);
    end
    send(vt[10], 1'b1);
    idle(6);

    // Bounded drain of anything still expected
    for (int w = 0; w < 50 && sb.size() != 0; w++) @(posedge clk);
    if (sb.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
